// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative signed multiply/divide
// sequencer.
//   state_e   : sequencer FSM states
//   op_kind_e : operation latched at start (multiply or divide)
//   WIDTH_DEF : default operand width
package mult_div_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    FIX,
    DZERO
  } state_e;

  typedef enum logic {
    OP_MULT,
    OP_DIV
  } op_kind_e;

endpackage

// File: rtl/mult_div_ctrl_if.sv
// Request/result bundle between the main control FSM (master) and the
// multiply/divide sequencer (slave).
//   start_mult/start_div : one-cycle requests from the control FSM
//   op_a/op_b            : rs/rt operand values
//   hi_out/lo_out        : HI/LO registers
//   busy/done/div_zero   : status back to the control FSM
interface mult_div_ctrl_if
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);

  logic             start_mult;
  logic             start_div;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start_mult, start_div, op_a, op_b,
    input  hi_out, lo_out, busy, done, div_zero
  );

  modport slave (
    input  start_mult, start_div, op_a, op_b,
    output hi_out, lo_out, busy, done, div_zero
  );

endinterface

// File: rtl/mult_div_step.sv
// One combinational iteration of the unsigned multiply/divide datapath.
//   acc_i : 2*WIDTH accumulator
//           mult: {partial product, remaining multiplier bits}
//           div : {partial remainder, remaining dividend / quotient bits}
//   mag_i : multiplicand magnitude (mult) or divisor magnitude (div)
//   op_i  : selects shift-add (OP_MULT) or restoring shift-subtract (OP_DIV)
//   acc_o : accumulator after this iteration
module mult_div_step
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   mag_i,
  input  op_kind_e           op_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_ext;
  logic [WIDTH:0]   diff;

  always_comb begin
    // Multiply: add the multiplicand into the upper half when the current
    // multiplier LSB is set, then shift right keeping the carry.
    addend = acc_i[0] ? mag_i : '0;
    sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, addend};

    // Divide: shift left one bit into the remainder; the extra top bit keeps
    // the trial subtraction exact so the borrow decides the quotient bit.
    rem_ext = acc_i[2*WIDTH-1:WIDTH-1];
    diff    = rem_ext - {1'b0, mag_i};

    acc_o = acc_i;
    if (op_i == OP_MULT) begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
    end else begin
      acc_o = {rem_ext[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_ctrl.sv
// Iterative signed multiply/divide sequencer with HI/LO registers.
//   clock : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : mult_div_ctrl_if.slave
//           start_mult/start_div + op_a/op_b in; hi_out/lo_out, busy,
//           done (one-cycle), div_zero (one-cycle) out
// Latency: start sampled at edge t -> HI/LO and done at edge t+WIDTH+2;
// divide by zero reported at edge t+1 with HI/LO untouched.
module mult_div_ctrl
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input logic            clock,
  input logic            reset,
  mult_div_ctrl_if.slave bus
);

  localparam int unsigned     CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q,    state_d;
  op_kind_e           op_q,       op_d;
  logic               sign_a_q,   sign_a_d;
  logic               sign_b_q,   sign_b_d;
  logic [WIDTH-1:0]   a_q,        a_d;
  logic [WIDTH-1:0]   b_q,        b_d;
  logic [WIDTH-1:0]   mag_q,      mag_d;
  logic [2*WIDTH-1:0] acc_q,      acc_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [WIDTH-1:0]   hi_q,       hi_d;
  logic [WIDTH-1:0]   lo_q,       lo_d;
  logic               busy_q,     busy_d;
  logic               done_q,     done_d;
  logic               div_zero_q, div_zero_d;

  logic [2*WIDTH-1:0] step_acc;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               neg_res;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  mult_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc_i(acc_q),
    .mag_i(mag_q),
    .op_i (op_q),
    .acc_o(step_acc)
  );

  // Magnitudes and sign-corrected results. The magnitude of the most
  // negative value is 2^(WIDTH-1), which still fits as an unsigned WIDTH.
  always_comb begin
    mag_a    = sign_a_q ? -a_q : a_q;
    mag_b    = sign_b_q ? -b_q : b_q;
    neg_res  = sign_a_q ^ sign_b_q;
    prod_fix = neg_res ? -acc_q : acc_q;
    quo_fix  = neg_res ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    a_d        = a_q;
    b_d        = b_q;
    mag_d      = mag_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    case (state_q)
      // DZERO already reports busy=0, so it accepts a start like IDLE.
      IDLE, DZERO: begin
        state_d = IDLE;
        if (bus.start_mult || bus.start_div) begin
          op_d     = bus.start_mult ? OP_MULT : OP_DIV;
          a_d      = bus.op_a;
          b_d      = bus.op_b;
          sign_a_d = bus.op_a[WIDTH-1];
          sign_b_d = bus.op_b[WIDTH-1];
          busy_d   = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (op_q == OP_DIV && b_q == '0) begin
          div_zero_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = DZERO;
        end else begin
          // Lower half is seeded with the operand that gets consumed one bit
          // per step (multiplier or dividend); upper half starts at zero.
          acc_d   = {{WIDTH{1'b0}}, (op_q == OP_MULT) ? mag_b : mag_a};
          mag_d   = (op_q == OP_MULT) ? mag_a : mag_b;
          cnt_d   = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        acc_d = step_acc;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIX: begin
        if (op_q == OP_MULT) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      op_q       <= OP_MULT;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      mag_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      a_q        <= a_d;
      b_q        <= b_d;
      mag_q      <= mag_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.hi_out   = hi_q;
  assign bus.lo_out   = lo_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Self-checking bench for mult_div_ctrl (WIDTH=32). Expected HI/LO come from
// plain 64-bit signed arithmetic; the bench keeps its own copy of HI/LO.
module tb_mult_div_ctrl;

  localparam int unsigned W = 32;

  logic clk;
  logic rst_n;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] model_hi;
  logic [W-1:0] model_lo;

  mult_div_ctrl_if #(.WIDTH(W)) bus ();

  mult_div_ctrl #(
    .WIDTH(W)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: signed 64-bit product, or C-style truncating quotient and
  // dividend-signed remainder, each cut to W bits.
  task automatic ref_op(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] eh, output logic [W-1:0] el);
    longint sa, sb, r, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!is_div) begin
      r  = sa * sb;
      eh = r[63:32];
      el = r[31:0];
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      eh = r[31:0];
      el = q[31:0];
    end
  endtask

  // Starts an op at the current negedge; returns at the negedge where done is
  // high (or two cycles after a divide-by-zero), so a following call is
  // back-to-back.
  task automatic run_op(input bit is_div, input bit both, input logic [W-1:0] a,
                        input logic [W-1:0] b, input string tag);
    logic [W-1:0] eh, el;
    int unsigned k;
    bit seen;
    bus.start_mult = !is_div;
    bus.start_div  = is_div | both;
    bus.op_a       = a;
    bus.op_b       = b;
    @(negedge clk);
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start: got %b want 1", tag, bus.busy);
    end
    if (is_div && b == '0) begin
      @(negedge clk);
      checks++;
      if (bus.div_zero !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
          bus.hi_out !== model_hi || bus.lo_out !== model_lo) begin
        errors++;
        $display("FAIL %s dz_report: dz=%b busy=%b done=%b hi=%h lo=%h want dz=1 busy=0 done=0 hi=%h lo=%h",
                 tag, bus.div_zero, bus.busy, bus.done, bus.hi_out, bus.lo_out, model_hi, model_lo);
      end
      @(negedge clk);
      checks++;
      if (bus.div_zero !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL %s dz_pulse_width: dz=%b done=%b want 0 0", tag, bus.div_zero, bus.done);
      end
    end else begin
      ref_op(is_div, a, b, eh, el);
      k = 0;
      seen = 0;
      while (!seen && k < W + 10) begin
        @(negedge clk);
        k++;
        if (bus.done === 1'b1) begin
          seen = 1;
        end else begin
          checks++;
          if (bus.busy !== 1'b1 || bus.div_zero !== 1'b0 ||
              bus.hi_out !== model_hi || bus.lo_out !== model_lo) begin
            errors++;
            $display("FAIL %s hold_k%0d: busy=%b dz=%b hi=%h lo=%h want busy=1 dz=0 hi=%h lo=%h",
                     tag, k, bus.busy, bus.div_zero, bus.hi_out, bus.lo_out, model_hi, model_lo);
          end
        end
      end
      checks++;
      if (!seen || k != W + 2) begin
        errors++;
        $display("FAIL %s latency: got %0d cycles (seen=%0d) want %0d", tag, k, seen, W + 2);
      end
      checks++;
      if (bus.hi_out !== eh || bus.lo_out !== el || bus.busy !== 1'b0 || bus.div_zero !== 1'b0) begin
        errors++;
        $display("FAIL %s result: hi=%h lo=%h busy=%b dz=%b want hi=%h lo=%h busy=0 dz=0",
                 tag, bus.hi_out, bus.lo_out, bus.busy, bus.div_zero, eh, el);
      end
      model_hi = eh;
      model_lo = el;
    end
  endtask

  task automatic idle_gap(input string tag);
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.div_zero !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: done=%b busy=%b dz=%b want 0 0 0", tag, bus.done, bus.busy, bus.div_zero);
    end
  endtask

  task automatic test_reset();
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.op_a       = '0;
    bus.op_b       = '0;
    rst_n          = 1'b0;
    model_hi       = '0;
    model_lo       = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_zero !== 1'b0 ||
        bus.hi_out !== '0 || bus.lo_out !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
               bus.busy, bus.done, bus.div_zero, bus.hi_out, bus.lo_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    run_op(0, 0, 32'd7, 32'hFFFF_FFFD, "mult_7x-3");
    checks++;
    if (bus.hi_out !== 32'hFFFF_FFFF || bus.lo_out !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL mult_7x-3_const: hi=%h lo=%h want ffffffff ffffffeb", bus.hi_out, bus.lo_out);
    end
    idle_gap("mult_7x-3");
  endtask

  task automatic test_div();
    run_op(1, 0, 32'd100, 32'd7, "div_100/7");
    checks++;
    if (bus.lo_out !== 32'd14 || bus.hi_out !== 32'd2) begin
      errors++;
      $display("FAIL div_100/7_const: hi=%h lo=%h want 2 e", bus.hi_out, bus.lo_out);
    end
    idle_gap("div_100/7");
    run_op(1, 0, -32'sd100, 32'd7, "div_-100/7");
    idle_gap("div_-100/7");
    run_op(1, 0, 32'd100, -32'sd7, "div_100/-7");
    idle_gap("div_100/-7");
  endtask

  task automatic test_div_zero();
    int unsigned dones, dzs;
    run_op(1, 0, 32'd68, 32'd7, "preload");
    idle_gap("preload");
    bus.start_div = 1'b1;
    bus.op_a      = 32'd1234;
    bus.op_b      = '0;
    @(negedge clk);
    bus.start_div = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.div_zero !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL div_zero_t1: dz=%b busy=%b want 1 0", bus.div_zero, bus.busy);
    end
    dones = 0;
    dzs = 0;
    repeat (W + 6) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
      if (bus.div_zero === 1'b1) dzs++;
    end
    checks++;
    if (dones != 0 || dzs != 0 || bus.hi_out !== 32'd5 || bus.lo_out !== 32'd9) begin
      errors++;
      $display("FAIL div_zero_after: dones=%0d extra_dz=%0d hi=%h lo=%h want 0 0 5 9",
               dones, dzs, bus.hi_out, bus.lo_out);
    end
  endtask

  task automatic test_corners();
    run_op(0, 0, 32'h8000_0000, 32'h8000_0000, "min_x_min");
    checks++;
    if (bus.hi_out !== 32'h4000_0000 || bus.lo_out !== 32'h0) begin
      errors++;
      $display("FAIL min_x_min_const: hi=%h lo=%h want 40000000 0", bus.hi_out, bus.lo_out);
    end
    idle_gap("min_x_min");
    run_op(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, "min_div_-1");
    checks++;
    if (bus.hi_out !== 32'h0 || bus.lo_out !== 32'h8000_0000) begin
      errors++;
      $display("FAIL min_div_-1_const: hi=%h lo=%h want 0 80000000", bus.hi_out, bus.lo_out);
    end
    idle_gap("min_div_-1");
    run_op(0, 0, 32'h0, 32'hDEAD_BEEF, "zero_x");
    idle_gap("zero_x");
    run_op(1, 0, 32'd5, 32'hFFFF_FFFF, "div_small_by_-1");
    idle_gap("div_small_by_-1");
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] a, b, eh, el;
    int unsigned k, dones, dzs, done_k;
    a = 32'h0001_E241;
    b = 32'hFFFF_FC21;
    ref_op(0, a, b, eh, el);
    bus.start_mult = 1'b1;
    bus.op_a       = a;
    bus.op_b       = b;
    @(negedge clk);
    bus.start_mult = 1'b0;
    k = 0;
    dones = 0;
    dzs = 0;
    done_k = 0;
    repeat (W + 8) begin
      @(negedge clk);
      k++;
      if (k == 5) begin
        bus.start_div = 1'b1;
        bus.op_a      = 32'd50;
        bus.op_b      = '0;
      end else begin
        bus.start_div = 1'b0;
      end
      if (bus.done === 1'b1) begin
        dones++;
        done_k = k;
        checks++;
        if (bus.hi_out !== eh || bus.lo_out !== el) begin
          errors++;
          $display("FAIL ignore_start_result: hi=%h lo=%h want %h %h", bus.hi_out, bus.lo_out, eh, el);
        end
      end
      if (bus.div_zero === 1'b1) dzs++;
    end
    model_hi = eh;
    model_lo = el;
    checks++;
    if (dones != 1 || done_k != W + 2 || dzs != 0) begin
      errors++;
      $display("FAIL ignore_start_count: dones=%0d at k=%0d dz=%0d want 1 at %0d dz=0",
               dones, done_k, dzs, W + 2);
    end
    run_op(0, 1, 32'd3, 32'd4, "simul_start");
    checks++;
    if (bus.lo_out !== 32'd12 || bus.hi_out !== 32'd0) begin
      errors++;
      $display("FAIL simul_start_const: hi=%h lo=%h want 0 c", bus.hi_out, bus.lo_out);
    end
    idle_gap("simul_start");
  endtask

  task automatic test_reset_mid();
    bus.start_mult = 1'b1;
    bus.op_a       = 32'h1234_5678;
    bus.op_b       = 32'h9ABC_DEF1;
    @(negedge clk);
    bus.start_mult = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi_out !== '0 || bus.lo_out !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h want all 0",
               bus.busy, bus.done, bus.hi_out, bus.lo_out);
    end
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(0, 0, 32'd2, 32'd3, "after_reset");
    checks++;
    if (bus.lo_out !== 32'd6 || bus.hi_out !== 32'd0) begin
      errors++;
      $display("FAIL after_reset_const: hi=%h lo=%h want 0 6", bus.hi_out, bus.lo_out);
    end
    idle_gap("after_reset");
  endtask

  task automatic test_back_to_back();
    run_op(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "b2b_0");
    run_op(1, 0, 32'h7FFF_FFFF, 32'd3, "b2b_1");
    run_op(0, 0, 32'h8000_0000, 32'h7FFF_FFFF, "b2b_2");
    idle_gap("b2b");
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [W-1:0] a, b;
    bit d;
    for (int i = 0; i < 24; i++) begin
      a = pick();
      b = pick();
      d = $urandom_range(0, 1) == 1;
      run_op(d, 0, a, b, $sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 1) idle_gap($sformatf("rand%0d", i));
    end
    idle_gap("rand_end");
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_corners();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
